registrador_deslocamento_universal: RTL
=======================================

Name: registrador_deslocamento_universal

Overview:
Parametrised universal shift register, the successor of the fixed 7-bit, mode-selected register. It adds configurable width, a ring (rotate) option in both directions and multi-step shift commands. A command is accepted with a start pulse and reports busy/done status. It sits in datapaths that need N-step shifts or rotates executed autonomously while the surrounding controller waits on concluido.

Parameters:
LARGURA, 7, register width in bits (>=2)
MAX_PASSOS, 7, maximum steps per command; PW = clog2(MAX_PASSOS+1) is the passos width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
ch  input  2  mode: 00 hold, 01 shift up (q[i]<=q[i-1]), 10 shift down (q[i]<=q[i+1]), 11 parallel load
rot  input  1  1 = ring feed (end bit re-enters), 0 = serial input feeds the vacated bit
d  input  1  serial input into q[0] for shift up
e  input  1  serial input into q[LARGURA-1] for shift down
bits  input  LARGURA  parallel load data
passos  input  PW  number of shift steps
partida  input  1  command start strobe
ocupado  output  1  command executing
concluido  output  1  one-cycle done pulse
saidas_registrador  output  LARGURA  full register contents q
saida_ultimoflip  output  1  q[LARGURA-1]
saida_primeiroflip  output  1  q[0]

Behaviour:
- Reset (synchronous, rst=1 at an edge): q=0, FSM=OCIOSO, ocupado=0, concluido=0. rst has priority over everything, including mid-command. An aborted command never produces concluido.
- FSM states: OCIOSO, EXEC, FIM. ocupado=1 only in EXEC. concluido=1 only in FIM, always for exactly one cycle.
- Acceptance: partida=1 at edge E0 while in OCIOSO or FIM latches ch, rot, bits and cnt. In any other state partida is ignored.
- cnt value at acceptance:
  - load/hold: cnt=1.
  - shift: cnt=min(passos, MAX_PASSOS).
- Transition at E0: cnt>0 -> EXEC; cnt=0 (shift with passos=0) -> FIM directly, q unchanged.
- EXEC: one step per edge E1..Ek, cnt decrements each step. The edge that performs the last step moves the FSM to FIM. FIM -> OCIOSO next edge unless a new command is accepted there (back-to-back allowed).
- Step semantics (N=LARGURA):
  - shift up: q[i]<=q[i-1] for i>=1; q[0] <= rot ? q[N-1] : d.
  - shift down: q[i]<=q[i+1] for i<=N-2; q[N-1] <= rot ? q[0] : e.
  - load: q<=latched bits.
  - hold: q unchanged.
- d and e are sampled live at each step edge, so a serial stream can be injected. Mode, rot and bits inputs are ignored while ocupado=1.
- Latency:
  - load: q valid after E1, concluido high in cycle after E1.
  - k-step shift: ocupado for k cycles, concluido in cycle after Ek.
- passos > MAX_PASSOS (possible when MAX_PASSOS != 2^PW-1): clamped to MAX_PASSOS.
- Outputs are registered state only, with no combinational path from inputs to outputs.

Decomposition:
- Package registrador_pkg holds:
  - mode constants MODO_HOLD/MODO_SOBE/MODO_DESCE/MODO_CARGA
  - FSM state enum (OCIOSO, EXEC, FIM)
  - PW function
- One sub-module, celula_registrador: a single bit cell that muxes hold / lower neighbour / upper neighbour / parallel bit into a flop. It is the generalised per-bit flipflop, instantiated LARGURA times via generate. End cells get the serial/ring feed mux in the top level.

Test Plan:
1. Reset, then ch=11 bits=1011001 partida at E0 -> saidas_registrador=1011001 after E1; ocupado high 1 cycle; concluido pulse in next cycle.
2. From 1011001, ch=01 rot=1 passos=3 -> ocupado 3 cycles; after the steps q=0110011, 1100110, then 1001101; concluido once.
3. From 0000001, ch=10 rot=0 e=1 passos=2 -> 1000000 then 1100000; saida_primeiroflip=0 at end.
4. passos=0 shift -> concluido the cycle after E0, q unchanged. Separately, a partida pulse during an active 5-step command is ignored: exactly 5 steps and one concluido.
5. rst asserted at step 2 of a 6-step shift -> q=0, ocupado=0 next cycle, no concluido ever.
6. LARGURA=16 MAX_PASSOS=15: load 0x0001, then ch=01 rot=1 passos=15 -> q=0x8000. A follow-up partida accepted in FIM executes immediately (back-to-back).

Source files
------------

// File: rtl/registrador_deslocamento_universal_pkg.sv
// Shared definitions for the universal shift register: mode codes,
// control FSM states and the step-count width helper.
package registrador_pkg;

    localparam logic [1:0] MODO_HOLD  = 2'b00;
    localparam logic [1:0] MODO_SOBE  = 2'b01;
    localparam logic [1:0] MODO_DESCE = 2'b10;
    localparam logic [1:0] MODO_CARGA = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EXEC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    function automatic int calc_pw(input int max_passos);
        return $clog2(max_passos + 1);
    endfunction

endpackage

// File: rtl/registrador_deslocamento_universal_celula.sv
// One register bit: selects hold, lower neighbour, upper neighbour or the
// parallel bit into its flop.
module celula_registrador
    import registrador_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       q_baixo,
    input  logic       q_cima,
    input  logic       bit_carga,
    output logic       q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case (sel)
                MODO_SOBE:  q <= q_baixo;
                MODO_DESCE: q <= q_cima;
                MODO_CARGA: q <= bit_carga;
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/registrador_deslocamento_universal.sv
// Parametrised universal shift register executing multi-step shift, rotate
// and load commands under a start/busy/done handshake.
module registrador_deslocamento_universal
    import registrador_pkg::*;
#(
    parameter  int LARGURA    = 7,
    parameter  int MAX_PASSOS = 7,
    localparam int PW         = calc_pw(MAX_PASSOS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         ch,
    input  logic               rot,
    input  logic               d,
    input  logic               e,
    input  logic [LARGURA-1:0] bits,
    input  logic [PW-1:0]      passos,
    input  logic               partida,
    output logic               ocupado,
    output logic               concluido,
    output logic [LARGURA-1:0] saidas_registrador,
    output logic               saida_ultimoflip,
    output logic               saida_primeiroflip
);

    localparam logic [PW-1:0] MAX_P = PW'(MAX_PASSOS);

    estado_t            estado, prox;
    logic [PW-1:0]      cnt, cnt_prox, cnt_ini;
    logic [1:0]         modo_r;
    logic               rot_r;
    logic [LARGURA-1:0] bits_r;
    logic [LARGURA-1:0] q, baixo, cima;
    logic [1:0]         sel_cel;
    logic               aceita;

    assign aceita = partida && (estado != EXEC);

    // Hold and load are single-step commands; shifts clamp to MAX_PASSOS.
    always_comb begin
        cnt_ini = PW'(1);
        if (ch == MODO_SOBE || ch == MODO_DESCE)
            cnt_ini = (passos > MAX_P) ? MAX_P : passos;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
            cnt    <= '0;
            modo_r <= MODO_HOLD;
            rot_r  <= 1'b0;
            bits_r <= '0;
        end else begin
            estado <= prox;
            cnt    <= cnt_prox;
            if (aceita) begin
                modo_r <= ch;
                rot_r  <= rot;
                bits_r <= bits;
            end
        end
    end

    always_comb begin
        prox     = estado;
        cnt_prox = cnt;
        case (estado)
            OCIOSO, FIM: begin
                prox = OCIOSO;
                if (partida) begin
                    cnt_prox = cnt_ini;
                    prox     = (cnt_ini == '0) ? FIM : EXEC;
                end
            end
            EXEC: begin
                cnt_prox = cnt - PW'(1);
                if (cnt == PW'(1))
                    prox = FIM;
            end
            default: prox = OCIOSO;
        endcase
    end

    // Cells only move while executing; end bits get the ring/serial feed here.
    assign sel_cel = (estado == EXEC) ? modo_r : MODO_HOLD;
    assign baixo   = {q[LARGURA-2:0], rot_r ? q[LARGURA-1] : d};
    assign cima    = {rot_r ? q[0] : e, q[LARGURA-1:1]};

    for (genvar i = 0; i < LARGURA; i++) begin : g_cel
        celula_registrador u_cel (
            .clk       (clk),
            .rst       (rst),
            .sel       (sel_cel),
            .q_baixo   (baixo[i]),
            .q_cima    (cima[i]),
            .bit_carga (bits_r[i]),
            .q         (q[i])
        );
    end

    assign ocupado            = (estado == EXEC);
    assign concluido          = (estado == FIM);
    assign saidas_registrador = q;
    assign saida_ultimoflip   = q[LARGURA-1];
    assign saida_primeiroflip = q[0];

endmodule
